bram_rr_arbiter: RTL
====================

Name: bram_rr_arbiter

Overview:
- Shares one 256x16 block RAM (SB_RAM40_4K, READ_MODE/WRITE_MODE 0) between two requesters, A and B.
- Each requester issues single-word reads or writes through a req/gnt handshake. At most one access per cycle reaches the RAM.
- Contention is resolved round-robin, or by fixed priority via parameter.
- Sits between LED/pattern logic (readers) and a loader or UART path (writer) in board-level designs.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin; 1 = A always wins when both request.
- CLEAR_VAL, 16'h0000, word written to every address by the clear sweep (only used with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- ready  out  1  high when arbiter accepts requests.
- a_req  in  1  requester A access request; hold until a_gnt.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  8  A word address.
- a_wdata  in  16  A write data.
- a_gnt  out  1  A access taken this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered).
- a_rdata  out  16  A read data; zero when a_rvalid = 0.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.

Behaviour:
- Reset (resetn = 0 at posedge):
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - last_gnt = B, so A wins the first tie.
  - ready = 1 from the first cycle after reset is released (see Optional Feature).
  - Any in-flight read is dropped; no rvalid for it.
- Grant (combinational, same cycle as req):
  - gnt only when ready = 1. Never both gnts at once.
  - Only one req high: that requester is granted.
  - Both req high, FIXED_PRIO = 0: grant the side that was not last_gnt. last_gnt updates on every grant.
  - Both req high, FIXED_PRIO = 1: A is granted.
  - A requester not granted keeps req, we, addr and wdata stable. Changing them before gnt is a protocol violation; behaviour is undefined and a bench assertion flags it.
- Access:
  - Granted write: RAM WE/WCLKE asserted, WADDR = addr, WDATA = wdata, MASK = 0. The word is committed at the posedge ending the grant cycle. No rvalid is produced.
  - Granted read: RAM RE asserted, RADDR = addr. Data appears after that posedge.
  - Read latency: x_rvalid is high exactly 1 cycle after the gnt cycle, for 1 cycle. x_rdata = RAM RDATA in that cycle, else 0.
  - Back-to-back grants are allowed every cycle; throughput is 1 access per cycle.
- Ordering:
  - A write at cycle N followed by a read of the same address granted at N+1 or later returns the new data.
  - A write and a read can never target the RAM in the same cycle.
- Fairness: under round-robin with both reqs held, grants alternate A,B,A,B. Maximum wait is 1 cycle.
- Address wrap: 8-bit address; 8'hFF is a valid last word, no wrap logic.

Optional Feature:
- Macro: BRAM_RR_ARBITER_CLEAR_EN.
- Defined: after reset, an FSM runs CLEAR -> RUN.
  - CLEAR: ready = 0 and both gnts = 0. A counter 0..255 writes CLEAR_VAL to each address, one per cycle.
  - The sweep takes 256 cycles. ready rises in the cycle after address 8'hFF is written.
  - Reset during CLEAR restarts the sweep at address 0.
- Undefined: no FSM and no counter. ready = 1 after reset; RAM contents are left unmodified.

Test Plan:
- A only: write 16'hBEEF at 8'h12, then read 8'h12 -> a_gnt in both cycles; a_rvalid one cycle after the read grant with a_rdata = 16'hBEEF; b_* outputs stay 0.
- Both requesters hold reads of 8'h00 and 8'h01 for 4 cycles -> grants A,B,A,B; each rvalid 1 cycle after its grant; data matches the stored words.
- FIXED_PRIO = 1, both requesting continuously -> b_gnt never asserts while a_req = 1; b_gnt in the first cycle after a_req drops.
- A writes 16'h1234 at 8'hFF, B reads 8'hFF in the next cycle -> b_rdata = 16'h1234.
- resetn pulled low in the cycle after a read grant -> no rvalid; all outputs 0; the first tie after reset goes to A.
- With BRAM_RR_ARBITER_CLEAR_EN and CLEAR_VAL = 16'hA5A5: ready = 0 for 256 cycles; then reads of 8'h00, 8'h80 and 8'hFF return 16'hA5A5; a req during the sweep gets no gnt.

Source files
------------

// File: rtl/bram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bram_rr_arbiter
//
// Shares one 256x16 block RAM (written so that it maps onto an iCE40
// SB_RAM40_4K in READ_MODE/WRITE_MODE 0) between two single-word requesters,
// A and B. At most one access per cycle reaches the RAM. Contention is
// resolved round-robin (FIXED_PRIO = 0) or with A always winning
// (FIXED_PRIO = 1).
//
// Optional feature: define BRAM_RR_ARBITER_CLEAR_EN to add a power-up sweep
// that writes CLEAR_VAL to all 256 words after every reset before the
// arbiter reports ready. Without the macro, ready rises one cycle after reset
// release and RAM contents are left untouched.
//
// Ports
//   clk        system clock, everything on posedge
//   resetn     synchronous active-low reset
//   ready      arbiter accepts requests
//   x_req      request, held until x_gnt               (x = a, b)
//   x_we       1 = write, 0 = read
//   x_addr     8-bit word address
//   x_wdata    16-bit write data
//   x_gnt      access taken this cycle (combinational)
//   x_rvalid   read data valid, one cycle after a read grant
//   x_rdata    read data, zero whenever x_rvalid is low
// -----------------------------------------------------------------------------
module bram_rr_arbiter #(
    parameter int          FIXED_PRIO = 0,
    parameter logic [15:0] CLEAR_VAL  = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ready,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [7:0]  a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [7:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata
);

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              w_run;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_data;

`ifdef BRAM_RR_ARBITER_CLEAR_EN
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_addr;

    // Sweep one word per cycle; the state flips to RUN on the edge that
    // commits address 8'hFF, so ready rises in the following cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == 8'hFF) begin
                r_state <= S_RUN;
            end
        end
    end

    assign w_run      = (r_state == S_RUN);
    assign w_clr_we   = resetn && (r_state == S_CLEAR);
    assign w_clr_addr = r_clr_addr;
`else
    logic r_run;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_run      = r_run;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    assign w_clr_data = CLEAR_VAL;

    // While resetn is low the arbiter takes nothing and every output reads
    // zero, which also hides a read that was granted just before reset.
    assign ready = w_run && resetn;

    // ---- stage p0: arbitration and RAM port selection ----
    logic r_last_b;     // 1 = B took the most recent grant
    logic w_a_wins_tie;

    assign w_a_wins_tie = (FIXED_PRIO != 0) || r_last_b;
    assign a_gnt        = ready && a_req && (!b_req || w_a_wins_tie);
    assign b_gnt        = ready && b_req && !a_gnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_b <= 1'b1;
        end else if (a_gnt || b_gnt) begin
            r_last_b <= b_gnt;
        end
    end

    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [ADDR_W-1:0] w_ram_raddr;
    logic [DATA_W-1:0] w_ram_wdata;

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_waddr = '0;
        w_ram_raddr = '0;
        w_ram_wdata = '0;
        if (w_clr_we) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_clr_addr;
            w_ram_wdata = w_clr_data;
        end else if (a_gnt) begin
            w_ram_we    = a_we;
            w_ram_re    = !a_we;
            w_ram_waddr = a_addr;
            w_ram_raddr = a_addr;
            w_ram_wdata = a_wdata;
        end else if (b_gnt) begin
            w_ram_we    = b_we;
            w_ram_re    = !b_we;
            w_ram_waddr = b_addr;
            w_ram_raddr = b_addr;
            w_ram_wdata = b_wdata;
        end
    end

    // ---- stage p1: RAM array, registered read data and valids ----
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata_p1;
    logic              r_a_rvalid_p1;
    logic              r_b_rvalid_p1;

    // Full-word writes (no mask); read data registered like the hard macro.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_waddr] <= w_ram_wdata;
        end
        if (w_ram_re) begin
            r_rdata_p1 <= r_mem[w_ram_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a_rvalid_p1 <= 1'b0;
            r_b_rvalid_p1 <= 1'b0;
        end else begin
            r_a_rvalid_p1 <= a_gnt && !a_we;
            r_b_rvalid_p1 <= b_gnt && !b_we;
        end
    end

    // One shared read register is enough: only one read is granted per cycle.
    assign a_rvalid = r_a_rvalid_p1 && resetn;
    assign b_rvalid = r_b_rvalid_p1 && resetn;
    assign a_rdata  = a_rvalid ? r_rdata_p1 : '0;
    assign b_rdata  = b_rvalid ? r_rdata_p1 : '0;

endmodule
